program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Byte-stream bootloader upstream of the MC14500B core's program memory.
//  Parses framed bytes (sync, length, instruction words, checksum).
//  Writes each assembled instruction word through the program RAM write port.
//  Holds the core (PC + ICU) in reset while loading and restarts it when a frame completes.
// PARAMETERS
//  ADDR_WIDTH   12   program address width; max frame length 2**ADDR_WIDTH words
//  DATA_WIDTH   16   instruction word width (opcode+address); multiple of 8
//  SYNC_BYTE    8'hA5 frame start marker
// PORTS
//  clk          in   1           single clock; all state changes on posedge
//  reset        in   1           synchronous, active-high
//  in_data      in   8           stream byte
//  in_valid     in   1           byte offered
//  in_ready     out  1           byte accepted when in_valid & in_ready
//  prog_write   out  1           1-cycle write strobe to program RAM
//  prog_address out  ADDR_WIDTH  write address
//  prog_data    out  DATA_WIDTH  write data
//  cpu_hold     out  1           holds core in reset while high
//  cpu_restart  out  1           1-cycle pulse on successful completion
//  load_error   out  1           sticky error flag; cleared by next sync byte
// BEHAVIOUR
//  Reset values: in_ready=0, prog_write=0, prog_address=0, prog_data=0,
//   cpu_hold=0, cpu_restart=0, load_error=0; state=IDLE. Reset wins over every other event.
//  in_ready=1 in IDLE, LEN_HI, LEN_LO, DATA, CSUM, ERROR; 0 in DONE and during reset.
//  Frame: SYNC, LEN[15:8], LEN[7:0], N x (DATA_WIDTH/8 bytes, MSB first), CSUM.
//  IDLE: non-sync bytes are discarded. SYNC -> LEN_HI; cpu_hold=1; load_error=0.
//  LEN_HI -> LEN_LO -> DATA (N>0) | CSUM (N=0). N>2**ADDR_WIDTH -> ERROR.
//  DATA: bytes shift into word register. The last byte of a word is accepted at cycle t.
//   At t+1: prog_write=1, prog_data=word, prog_address=word index.
//   prog_address increments after each write.
//   After word N-1: -> CSUM. At word index 2**ADDR_WIDTH-1 the address must not wrap early.
//  in_valid gaps anywhere in the frame: state holds indefinitely; there is no timeout.
//  Checksum: 8-bit sum mod 256 of the length and data bytes (SYNC excluded).
//  CSUM: byte == sum -> DONE, else -> ERROR.
//  DONE (1 cycle): cpu_hold=0 and cpu_restart=1 registered in the same cycle; -> IDLE.
//  ERROR: load_error=1; cpu_hold stays 1, leaving a partial image frozen.
//   Non-sync bytes are discarded. SYNC -> LEN_HI, same as IDLE.
//  A SYNC value inside LEN/DATA/CSUM is plain data; there is no resync mid-frame.
//  Reset mid-frame: outputs go to reset values. Words already written stay in RAM.
//   The next frame restarts at address 0.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: CSUM byte is required and checked as above.
//  Not defined: there is no CSUM byte and load_error is raised only on length overflow.
//   After the last word (or N=0) -> DONE directly. The sum accumulator is not built.
// STRUCTURE
//  Package loader_pkg: loader_state_t enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE,
//   ERROR), SYNC_BYTE_DEFAULT, BYTES_PER_WORD = DATA_WIDTH/8.
//  Sub-module word_packer: byte shift register plus byte counter.
//   Emits word_ready and the packed word. The FSM, address counter and checksum stay top-level.
// TESTING
//  1 A5 00 02 12 34 56 78 16 -> writes [0]=1234, [1]=5678; cpu_restart pulse;
//    cpu_hold 1->0; load_error=0.
//  2 Same frame with CSUM 17 -> both writes occur; load_error=1; cpu_hold stays 1.
//    Then frame 1 is resent -> success and load_error clears on the SYNC byte.
//  3 A5 10 01 -> ERROR after LEN_LO with no prog_write; subsequent data bytes are discarded.
//  4 Reset after A5 00 02 12 34 56 -> all outputs at reset values.
//    Frame 1 is then sent -> writes start at address 0.
//  5 Bytes 00 FF 3C precede frame 1, and in_valid drops for 5 cycles between 34 and 56
//    -> identical writes and timing relative to accepted bytes.
//  6 LOADER_CHECKSUM_EN undefined: A5 00 01 AB CD -> write [0]=ABCD, then
//    cpu_restart one cycle after the write strobe.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, constants and checksum helper for the program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT  = 8'hA5;
    localparam int         DATA_WIDTH_DEFAULT = 16;
    localparam int         BYTES_PER_WORD     = DATA_WIDTH_DEFAULT / 8;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: shifts stream bytes MSB-first into a word and flags the byte that completes it.
module word_packer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  word_ready,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] shift_r;
    logic [CW-1:0]         count_r;
    logic [DATA_WIDTH+7:0] ext_s;

    // The completed word includes the byte being accepted this cycle.
    assign ext_s      = {shift_r, byte_data};
    assign word       = ext_s[DATA_WIDTH-1:0];
    assign word_ready = byte_valid && (count_r == CW'(BPW - 1));

    // Byte shift register and position-within-word counter.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_r <= {DATA_WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (byte_valid) begin
            shift_r <= word;
            if (word_ready) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte-stream bootloader for the MC14500B program RAM.
// Define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  prog_write,
    output logic [ADDR_WIDTH-1:0] prog_address,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  cpu_hold,
    output logic                  cpu_restart,
    output logic                  load_error
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_PAYLOAD = CSUM;
`else
    localparam loader_state_t AFTER_PAYLOAD = DONE;
`endif

    loader_state_t         state_r, next_state_s;
    logic                  accept_s, sync_s, word_ready_s, last_word_s, overflow_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic [15:0]           len_r, len_full_s;
    logic [ADDR_WIDTH:0]   word_idx_r;
    logic                  in_ready_r, prog_write_r, cpu_hold_r, cpu_restart_r, load_error_r;
    logic [ADDR_WIDTH-1:0] prog_address_r;
    logic [DATA_WIDTH-1:0] prog_data_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_r;
`endif

    assign accept_s    = in_valid && in_ready_r;
    assign sync_s      = accept_s && ((state_r == IDLE) || (state_r == ERROR)) && (in_data == SYNC_BYTE);
    assign len_full_s  = {len_r[15:8], in_data};
    assign overflow_s  = {1'b0, len_full_s} > MAX_WORDS;
    // word_idx_r is one bit wider than the address so a full 2**ADDR_WIDTH frame terminates cleanly.
    assign last_word_s = word_ready_s && ((17'(word_idx_r) + 17'd1) == {1'b0, len_r});

    word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (sync_s),
        .byte_valid (accept_s && (state_r == DATA)),
        .byte_data  (in_data),
        .word_ready (word_ready_s),
        .word       (word_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame parser next-state logic; a sync value mid-frame is ordinary data.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, ERROR: begin
                if (sync_s) next_state_s = LEN_HI;
                else        next_state_s = state_r;
            end
            LEN_HI: begin
                if (accept_s) next_state_s = LEN_LO;
                else          next_state_s = state_r;
            end
            LEN_LO: begin
                if (!accept_s)                 next_state_s = state_r;
                else if (overflow_s)           next_state_s = ERROR;
                else if (len_full_s == 16'd0)  next_state_s = AFTER_PAYLOAD;
                else                           next_state_s = DATA;
            end
            DATA: begin
                if (last_word_s) next_state_s = AFTER_PAYLOAD;
                else             next_state_s = state_r;
            end
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (!accept_s)              next_state_s = state_r;
                else if (in_data == sum_r)  next_state_s = DONE;
                else                        next_state_s = ERROR;
`else
                next_state_s = IDLE;
`endif
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Frame bookkeeping: captured length, word index and running checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r      <= 16'd0;
            word_idx_r <= {(ADDR_WIDTH+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
            sum_r      <= 8'd0;
`endif
        end else begin
            if (sync_s) begin
                word_idx_r <= {(ADDR_WIDTH+1){1'b0}};
            end else if (word_ready_s) begin
                word_idx_r <= word_idx_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            if (accept_s && (state_r == LEN_HI)) len_r[15:8] <= in_data;
            if (accept_s && (state_r == LEN_LO)) len_r[7:0]  <= in_data;
`ifdef LOADER_CHECKSUM_EN
            if (sync_s) begin
                sum_r <= 8'd0;
            end else if (accept_s && ((state_r == LEN_HI) || (state_r == LEN_LO) || (state_r == DATA))) begin
                sum_r <= csum_add(sum_r, in_data);
            end
`endif
        end
    end

    // Registered outputs; restart and hold release land together the cycle after DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r     <= 1'b0;
            prog_write_r   <= 1'b0;
            prog_address_r <= {ADDR_WIDTH{1'b0}};
            prog_data_r    <= {DATA_WIDTH{1'b0}};
            cpu_hold_r     <= 1'b0;
            cpu_restart_r  <= 1'b0;
            load_error_r   <= 1'b0;
        end else begin
            in_ready_r    <= (next_state_s != DONE);
            prog_write_r  <= word_ready_s;
            cpu_restart_r <= (state_r == DONE);
            if (word_ready_s) begin
                prog_data_r    <= word_s;
                prog_address_r <= word_idx_r[ADDR_WIDTH-1:0];
            end
            if (sync_s) begin
                cpu_hold_r <= 1'b1;
            end else if (state_r == DONE) begin
                cpu_hold_r <= 1'b0;
            end
            if (sync_s) begin
                load_error_r <= 1'b0;
            end else if (next_state_s == ERROR) begin
                load_error_r <= 1'b1;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign prog_write   = prog_write_r;
    assign prog_address = prog_address_r;
    assign prog_data    = prog_data_r;
    assign cpu_hold     = cpu_hold_r;
    assign cpu_restart  = cpu_restart_r;
    assign load_error   = load_error_r;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames plus randomized traffic checked cycle-by-cycle against a frame-level model.
module tb_program_loader;

    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int BPW  = DW / 8;
    localparam int MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, prog_write, cpu_hold, cpu_restart, load_error;
    logic [7:0]    in_data;
    logic [AW-1:0] prog_address;
    logic [DW-1:0] prog_data;

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .prog_write   (prog_write),
        .prog_address (prog_address),
        .prog_data    (prog_data),
        .cpu_hold     (cpu_hold),
        .cpu_restart  (cpu_restart),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_writes = 0;
    int n_restarts = 0;

    // Expected outputs for the current cycle.
    bit         exp_valid = 1'b0;
    bit         e_ready, e_write, e_hold, e_restart, e_err;
    bit         e_done = 1'b0;
    int         e_addr;
    logic [15:0] e_data;
    // Frame-level view: bytes counted since sync, declared length, running sum, word being built.
    bit         active = 1'b0;
    int         k, len;
    logic [7:0] sum;
    logic [15:0] wacc;
    logic [7:0] fq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic payload_end();
`ifdef LOADER_CHECKSUM_EN
        // checksum byte follows
`else
        active = 1'b0;
        e_done = 1'b1;
`endif
    endtask

    task automatic consume(input logic [7:0] b);
        int d;
        if (!active) begin
            if (b == 8'hA5) begin
                active = 1'b1; k = 0; sum = 8'd0; wacc = 16'd0; e_hold = 1'b1; e_err = 1'b0;
            end
        end else begin
            if (k == 0) begin
                len = int'(b) * 256; sum = sum + b;
            end else if (k == 1) begin
                len = len + int'(b); sum = sum + b;
                if (len > MAXW) begin active = 1'b0; e_err = 1'b1; end
                else if (len == 0) payload_end();
            end else if (k < 2 + len * BPW) begin
                d = k - 2; sum = sum + b;
                wacc = (wacc << 8) | 16'(b);
                if (d % BPW == BPW - 1) begin
                    e_write = 1'b1; e_addr = d / BPW; e_data = wacc;
                    if (d / BPW == len - 1) payload_end();
                end
            end else begin
                active = 1'b0;
                if (b == sum) e_done = 1'b1;
                else          e_err  = 1'b1;
            end
            k++;
        end
    endtask

    // One clock cycle: compare this cycle's outputs, drive inputs, advance the model across the edge.
    task automatic tick(input logic v, input logic [7:0] b, input logic rst, output bit acc);
        bit was_done;
        if (exp_valid) begin
            check("in_ready",     32'(in_ready),     32'(e_ready));
            check("prog_write",   32'(prog_write),   32'(e_write));
            check("prog_address", 32'(prog_address), 32'(e_addr));
            check("prog_data",    32'(prog_data),    32'(e_data));
            check("cpu_hold",     32'(cpu_hold),     32'(e_hold));
            check("cpu_restart",  32'(cpu_restart),  32'(e_restart));
            check("load_error",   32'(load_error),   32'(e_err));
        end
        if (prog_write === 1'b1)  n_writes++;
        if (cpu_restart === 1'b1) n_restarts++;
        in_valid = v; in_data = b; reset = rst;
        acc = v && e_ready && !rst && exp_valid;
        was_done = e_done;
        e_write = 1'b0; e_restart = 1'b0; e_done = 1'b0;
        if (rst) begin
            e_ready = 1'b0; e_addr = 0; e_data = 16'd0; e_hold = 1'b0; e_err = 1'b0; active = 1'b0;
        end else begin
            if (was_done) begin e_restart = 1'b1; e_hold = 1'b0; end
            if (acc) consume(b);
            e_ready = !e_done;
        end
        exp_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom_range(0, 255)), 1'b0, a);
    endtask

    task automatic do_reset();
        bit a;
        tick(1'b0, 8'd0, 1'b1, a);
        tick(1'b0, 8'd0, 1'b1, a);
        tick(1'b0, 8'd0, 1'b0, a);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit a;
        int tries;
        idle(gap);
        a = 1'b0; tries = 0;
        while (!a && tries < 20) begin
            tick(1'b1, b, 1'b0, a);
            tries++;
        end
        if (!a) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_fq(input int max_gap);
        for (int i = 0; i < fq.size(); i++) send_byte(fq[i], $urandom_range(0, max_gap));
    endtask

    task automatic push_csum(input bit good);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 1; i < fq.size(); i++) s = s + fq[i];
`ifdef LOADER_CHECKSUM_EN
        fq.push_back(good ? s : (s ^ 8'h01));
`endif
    endtask

    task automatic frame1();
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h00); fq.push_back(8'h02);
        fq.push_back(8'h12); fq.push_back(8'h34); fq.push_back(8'h56); fq.push_back(8'h78);
    endtask

    task automatic garbage(input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, $urandom_range(0, 1));
        end
    endtask

    initial begin
        int w0, r0, n, mode, cut;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0;
        @(negedge clk);
        do_reset();
        idle(2);

        // Basic good frame.
        w0 = n_writes; r0 = n_restarts;
        frame1(); push_csum(1'b1); send_fq(0); idle(4);
        check("t1_writes", 32'(n_writes - w0), 32'd2);
        check("t1_restart", 32'(n_restarts - r0), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_addr", 32'(prog_address), 32'd1);
        check("t1_data", 32'(prog_data), 32'h5678);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum freezes the image, then a good resend recovers.
        w0 = n_writes; r0 = n_restarts;
        frame1(); fq.push_back(8'h17); send_fq(0); idle(3);
        check("t2_writes", 32'(n_writes - w0), 32'd2);
        check("t2_restart", 32'(n_restarts - r0), 32'd0);
        check("t2_err", 32'(load_error), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        frame1(); push_csum(1'b1); send_fq(0); idle(4);
        check("t2_recover_err", 32'(load_error), 32'd0);
        check("t2_recover_restart", 32'(n_restarts - r0), 32'd1);
`else
        // Two-byte word, no checksum: restart one cycle after the strobe.
        w0 = n_writes; r0 = n_restarts;
        fq.delete(); fq.push_back(8'hA5); fq.push_back(8'h00); fq.push_back(8'h01);
        fq.push_back(8'hAB); fq.push_back(8'hCD); send_fq(0); idle(4);
        check("t6_writes", 32'(n_writes - w0), 32'd1);
        check("t6_data", 32'(prog_data), 32'hABCD);
        check("t6_restart", 32'(n_restarts - r0), 32'd1);
`endif

        // Length overflow, then trailing data is discarded.
        w0 = n_writes;
        fq.delete(); fq.push_back(8'hA5); fq.push_back(8'h10); fq.push_back(8'h01);
        fq.push_back(8'h12); fq.push_back(8'h34); send_fq(0); idle(2);
        check("t3_writes", 32'(n_writes - w0), 32'd0);
        check("t3_err", 32'(load_error), 32'd1);

        // Reset mid-frame, then a full frame starts again at address 0.
        frame1(); void'(fq.pop_back()); send_fq(0);
        do_reset();
        check("t4_hold", 32'(cpu_hold), 32'd0);
        check("t4_addr", 32'(prog_address), 32'd0);
        frame1(); push_csum(1'b1); send_fq(0); idle(3);

        // Leading garbage and a 5-cycle gap between 34 and 56.
        w0 = n_writes;
        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h3C, 0);
        frame1(); push_csum(1'b1);
        for (int i = 0; i < fq.size(); i++) send_byte(fq[i], (i == 5) ? 5 : 0);
        idle(3);
        check("t5_writes", 32'(n_writes - w0), 32'd2);

        // Largest legal frame: address must reach the top without wrapping.
        w0 = n_writes;
        fq.delete(); fq.push_back(8'hA5); fq.push_back(8'(MAXW >> 8)); fq.push_back(8'(MAXW & 255));
        for (int i = 0; i < MAXW * BPW; i++) fq.push_back(8'($urandom_range(0, 255)));
        push_csum(1'b1); send_fq(0); idle(3);
        check("max_writes", 32'(n_writes - w0), 32'(MAXW));
        check("max_err", 32'(load_error), 32'd0);

        // Randomized frames: lengths, data, gaps, corrupt checksums, overflows, resets.
        for (int it = 0; it < 40; it++) begin
            garbage($urandom_range(0, 2));
            mode = $urandom_range(0, 9);
            fq.delete(); fq.push_back(8'hA5);
            if (mode == 0) begin
                n = MAXW + 1 + $urandom_range(0, 200);
                fq.push_back(8'(n >> 8)); fq.push_back(8'(n & 255));
                fq.push_back(8'($urandom_range(0, 255)));
            end else begin
                n = $urandom_range(0, 5);
                fq.push_back(8'(n >> 8)); fq.push_back(8'(n & 255));
                for (int i = 0; i < n * BPW; i++) fq.push_back(8'($urandom_range(0, 255)));
                push_csum(mode != 1);
            end
            if (mode == 2) begin
                cut = fq.size() / 2;
                for (int i = 0; i < cut; i++) send_byte(fq[i], $urandom_range(0, 2));
                do_reset();
            end else begin
                send_fq(2);
            end
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
